// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: word type, PC-select encoding and FSM states.
package fetch_sequencer_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        NEXT         = 2'd0,
        JUMP         = 2'd1,
        JUMPREGISTER = 2'd2,
        BRANCH       = 2'd3
    } pcselect_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Wraps modulo 2^32 by construction.
    function automatic word_t branch_target(input word_t npc, input logic [15:0] imm);
        return npc + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_arb.sv
// Combinational redirect arbiter: picks the oldest redirect source and forms its absolute target.
module fetch_sequencer_redirect_arb
    import fetch_sequencer_pkg::*;
(
    input  logic        stall,
    input  logic        id_jump,
    input  logic [3:0]  id_npc_hi,
    input  logic [25:0] id_jtarget,
    input  logic        ex_branch_taken,
    input  word_t       ex_npc,
    input  logic [15:0] ex_imm,
    input  logic        ex_jr,
    input  word_t       ex_jr_addr,
    output logic        redirect_valid,
    output word_t       redirect_target,
    output logic        redirect_is_ex
);

    logic ex_valid;
    logic id_valid;

    assign ex_valid = ex_branch_taken | ex_jr;
    assign id_valid = id_jump & ~stall & ~ex_valid;

    always_comb begin
        redirect_valid  = ex_valid | id_valid;
        redirect_is_ex  = ex_valid;
        redirect_target = '0;
        // JR beats a simultaneous taken branch; EX beats ID as the older instruction.
        if (ex_jr) begin
            redirect_target = ex_jr_addr;
        end else if (ex_branch_taken) begin
            redirect_target = branch_target(ex_npc, ex_imm);
        end else if (id_valid) begin
            redirect_target = {id_npc_hi, id_jtarget, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: sequences the PC block, instruction-memory enable, redirects and flushes.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        id_jump,
    input  logic [31:0] id_npc,
    input  logic [25:0] id_jtarget,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_npc,
    input  logic [15:0] ex_imm,
    input  logic        ex_jr,
    input  logic [31:0] ex_jr_addr,
    output logic        iren,
    output logic [1:0]  pc_select,
    output logic [31:0] jump_data,
    output logic        pc_halt,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    word_t        pend_target_q, pend_target_d;
    logic         pend_is_ex_q, pend_is_ex_d;

    logic  redirect_valid;
    word_t redirect_target;
    logic  redirect_is_ex;
    logic  ex_redirect;

    logic  apply_now;
    word_t apply_target;
    logic  apply_ex;

    // Only the region bits of the ID PC feed the jump target.
    logic unused_id_npc_bits;
    assign unused_id_npc_bits = ^id_npc[27:0];

    fetch_sequencer_redirect_arb u_redirect_arb (
        .stall           (stall),
        .id_jump         (id_jump),
        .id_npc_hi       (id_npc[31:28]),
        .id_jtarget      (id_jtarget),
        .ex_branch_taken (ex_branch_taken),
        .ex_npc          (ex_npc),
        .ex_imm          (ex_imm),
        .ex_jr           (ex_jr),
        .ex_jr_addr      (ex_jr_addr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_is_ex  (redirect_is_ex)
    );

    assign ex_redirect = redirect_valid & redirect_is_ex;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= RUN;
            pend_target_q <= '0;
            pend_is_ex_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            pend_is_ex_q  <= pend_is_ex_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pend_is_ex_d  = pend_is_ex_q;
        apply_now     = 1'b0;
        apply_target  = '0;
        apply_ex      = 1'b0;
        iren          = 1'b1;
        pc_select     = NEXT;
        jump_data     = pend_target_q;
        pc_halt       = ~ihit | stall;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        halted        = 1'b0;

        if (!RST) begin
            unique case (state_q)
                RUN: begin
                    if (redirect_valid) begin
                        if (ihit) begin
                            apply_now    = 1'b1;
                            apply_target = redirect_target;
                            apply_ex     = redirect_is_ex;
                        end else begin
                            pc_halt       = 1'b1;
                            pend_target_d = redirect_target;
                            pend_is_ex_d  = redirect_is_ex;
                            state_d       = HOLD;
                        end
                    end else if (halt_req) begin
                        state_d = DRAIN;
                    end
                end
                HOLD: begin
                    pc_halt = 1'b1;
                    // A fresh EX redirect replaces whatever was pending; ID jumps are dropped.
                    if (ex_redirect) begin
                        pend_target_d = redirect_target;
                        pend_is_ex_d  = 1'b1;
                    end
                    if (ihit) begin
                        apply_now    = 1'b1;
                        apply_target = ex_redirect ? redirect_target : pend_target_q;
                        apply_ex     = ex_redirect | pend_is_ex_q;
                        state_d      = RUN;
                    end
                end
                DRAIN: begin
                    pc_halt = 1'b1;
                    if (ex_redirect) begin
                        if (ihit) begin
                            apply_now    = 1'b1;
                            apply_target = redirect_target;
                            apply_ex     = 1'b1;
                            state_d      = RUN;
                        end else begin
                            pend_target_d = redirect_target;
                            pend_is_ex_d  = 1'b1;
                            state_d       = HOLD;
                        end
                    end else if (ihit) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    iren    = 1'b0;
                    pc_halt = 1'b1;
                    halted  = 1'b1;
                end
                default: ;
            endcase

            if (apply_now) begin
                pc_halt    = 1'b0;
                pc_select  = JUMPREGISTER;
                jump_data  = apply_target;
                flush_ifid = 1'b1;
                flush_idex = apply_ex;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit, stall, halt_req, id_jump, ex_branch_taken, ex_jr;
    logic [31:0] id_npc, ex_npc, ex_jr_addr;
    logic [25:0] id_jtarget;
    logic [15:0] ex_imm;
    logic        iren, pc_halt, flush_ifid, flush_idex, halted;
    logic [1:0]  pc_select;
    logic [31:0] jump_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] SEL_NEXT = 2'd0;
    localparam logic [1:0] SEL_JR   = 2'd2;

    fetch_sequencer dut (
        .CLK             (CLK),
        .RST             (RST),
        .ihit            (ihit),
        .stall           (stall),
        .halt_req        (halt_req),
        .id_jump         (id_jump),
        .id_npc          (id_npc),
        .id_jtarget      (id_jtarget),
        .ex_branch_taken (ex_branch_taken),
        .ex_npc          (ex_npc),
        .ex_imm          (ex_imm),
        .ex_jr           (ex_jr),
        .ex_jr_addr      (ex_jr_addr),
        .iren            (iren),
        .pc_select       (pc_select),
        .jump_data       (jump_data),
        .pc_halt         (pc_halt),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .halted          (halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control outputs in one go: select, pc_halt, both flushes.
    task automatic check_ctl(input string tag, input logic [1:0] sel, input logic hlt,
                             input logic fi, input logic fe);
        check({tag, ".sel"}, {30'd0, pc_select}, {30'd0, sel});
        check({tag, ".pc_halt"}, {31'd0, pc_halt}, {31'd0, hlt});
        check({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
        check({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fe});
    endtask

    task automatic clr();
        ihit = 1'b1; stall = 1'b0; halt_req = 1'b0; id_jump = 1'b0;
        ex_branch_taken = 1'b0; ex_jr = 1'b0;
        id_npc = '0; id_jtarget = '0; ex_npc = '0; ex_imm = '0; ex_jr_addr = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] npc, input logic [15:0] imm);
        ex_branch_taken = 1'b1; ex_npc = npc; ex_imm = imm;
    endtask

    task automatic set_jump();
        id_jump = 1'b1; id_npc = 32'h4000_0010; id_jtarget = 26'h40;
    endtask

    initial begin
        clr();
        #1 RST = 1'b1;
        #1;
        check("rst.iren", {31'd0, iren}, 32'd1);
        check("rst.jump_data", jump_data, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check_ctl("rst.idle", SEL_NEXT, 1'b0, 1'b0, 1'b0);
        // Redirect inputs during reset must not leak to the outputs.
        set_branch(32'h100, 16'hFFFE);
        ihit = 1'b0;
        #1;
        check("rst.redir.jd", jump_data, 32'd0);
        check_ctl("rst.redir", SEL_NEXT, 1'b1, 1'b0, 1'b0);
        clr();
        #5 RST = 1'b0;
        cyc();

        for (int i = 0; i < 3; i++) begin
            check("idle.iren", {31'd0, iren}, 32'd1);
            check_ctl("idle", SEL_NEXT, 1'b0, 1'b0, 1'b0);
            cyc();
        end

        stall = 1'b1;
        #1 check_ctl("stall", SEL_NEXT, 1'b1, 1'b0, 1'b0);
        cyc(); clr();

        // Taken branch with backward offset: 0x100 - 8.
        set_branch(32'h100, 16'hFFFE);
        #1;
        check("br.jd", jump_data, 32'h0000_00F8);
        check_ctl("br", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();

        // Forward branch wrapping past 2^32.
        set_branch(32'hFFFF_FFFC, 16'h0002);
        #1 check("br.wrap.jd", jump_data, 32'h0000_0004);
        cyc(); clr();

        // ID jump loses to JR in EX.
        set_jump();
        ex_jr = 1'b1; ex_jr_addr = 32'h200;
        #1;
        check("jr_vs_j.jd", jump_data, 32'h200);
        check_ctl("jr_vs_j", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();

        set_jump();
        #1;
        check("j.jd", jump_data, 32'h4000_0100);
        check_ctl("j", SEL_JR, 1'b0, 1'b1, 1'b0);
        cyc(); clr();

        set_jump(); stall = 1'b1;
        #1 check_ctl("j.stall", SEL_NEXT, 1'b1, 1'b0, 1'b0);
        cyc(); clr();

        // EX redirect wins over stall; JR wins over simultaneous branch.
        set_branch(32'h100, 16'h0004);
        ex_jr = 1'b1; ex_jr_addr = 32'h0000_0ABC; stall = 1'b1;
        #1;
        check("jr_vs_br.jd", jump_data, 32'h0000_0ABC);
        check_ctl("jr_vs_br", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();

        // Branch to 0x1040 while the fetch is outstanding for 3 cycles.
        set_branch(32'h1000, 16'h0010); ihit = 1'b0;
        #1 check_ctl("hold0", SEL_NEXT, 1'b1, 1'b0, 1'b0);
        cyc(); clr();
        ihit = 1'b0; set_jump();
        for (int i = 0; i < 2; i++) begin
            #1 check_ctl("hold.wait", SEL_NEXT, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        ihit = 1'b1;
        #1;
        check("hold.apply.jd", jump_data, 32'h0000_1040);
        check_ctl("hold.apply", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();
        #1 check_ctl("hold.back", SEL_NEXT, 1'b0, 1'b0, 1'b0);
        cyc();

        // EX redirect in HOLD overwrites the pending JR target.
        ex_jr = 1'b1; ex_jr_addr = 32'h300; ihit = 1'b0;
        cyc(); clr(); ihit = 1'b0;
        set_branch(32'h100, 16'hFFFE);
        cyc(); clr();
        #1;
        check("hold.ovr.jd", jump_data, 32'h0000_00F8);
        check_ctl("hold.ovr", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();

        // Pending ID jump only squashes IF/ID.
        set_jump(); ihit = 1'b0;
        cyc(); clr();
        #1;
        check("hold.j.jd", jump_data, 32'h4000_0100);
        check_ctl("hold.j", SEL_JR, 1'b0, 1'b1, 1'b0);
        cyc(); clr();

        // Halt with the fetch outstanding, then drain and stop.
        halt_req = 1'b1; ihit = 1'b0;
        cyc(); clr(); ihit = 1'b0;
        #1;
        check("drain.iren", {31'd0, iren}, 32'd1);
        check("drain.halted", {31'd0, halted}, 32'd0);
        check_ctl("drain", SEL_NEXT, 1'b1, 1'b0, 1'b0);
        cyc(); clr();
        #1 check("drain.ihit.halted", {31'd0, halted}, 32'd0);
        check("drain.ihit.pc_halt", {31'd0, pc_halt}, 32'd1);
        cyc(); clr();
        for (int i = 0; i < 2; i++) begin
            set_branch(32'h100, 16'hFFFE);
            #1;
            check("halted.halted", {31'd0, halted}, 32'd1);
            check("halted.iren", {31'd0, iren}, 32'd0);
            check_ctl("halted", SEL_NEXT, 1'b1, 1'b0, 1'b0);
            cyc(); clr();
        end
        RST = 1'b1;
        #1;
        check("halted.rst.halted", {31'd0, halted}, 32'd0);
        check("halted.rst.iren", {31'd0, iren}, 32'd1);
        RST = 1'b0;
        cyc();
        check_ctl("after_rst", SEL_NEXT, 1'b0, 1'b0, 1'b0);

        // EX redirect during DRAIN cancels the halt.
        halt_req = 1'b1;
        cyc(); clr();
        set_branch(32'h100, 16'hFFFE);
        #1;
        check("drain.br.jd", jump_data, 32'h0000_00F8);
        check_ctl("drain.br", SEL_JR, 1'b0, 1'b1, 1'b1);
        cyc(); clr();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("cancel.halted", {31'd0, halted}, 32'd0);
            check("cancel.iren", {31'd0, iren}, 32'd1);
            check_ctl("cancel", SEL_NEXT, 1'b0, 1'b0, 1'b0);
            cyc();
        end

        // Reset in HOLD discards the pending target.
        ex_jr = 1'b1; ex_jr_addr = 32'h300; ihit = 1'b0;
        cyc(); clr();
        RST = 1'b1;
        #1 check("hold.rst.jd", jump_data, 32'd0);
        RST = 1'b0;
        #1 check_ctl("hold.rst.after", SEL_NEXT, 1'b0, 1'b0, 1'b0);
        check("hold.rst.after.jd", jump_data, 32'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the program counter block each cycle. It arbitrates redirect requests from the decode stage (J/JAL) and the execute stage (taken branch, JR), and converts each into an absolute target. It then drives the PC's select, jump-data and halt controls, together with the instruction-memory read enable and pipeline flushes. It sits between the hazard unit, the ID/EX stages, the PC block and the instruction-memory port.

## Interface
Parameters:
- none; word width is fixed at 32 via the shared cpu types package.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction-memory read complete this cycle.
- stall  in  1  hazard-unit stall request for IF/ID.
- halt_req  in  1  HALT instruction reached ID.
- id_jump  in  1  J/JAL decoded in ID.
- id_npc  in  32  PC+4 of the ID instruction.
- id_jtarget  in  26  J-format target field.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_npc  in  32  PC+4 of the EX instruction.
- ex_imm  in  16  branch immediate.
- ex_jr  in  1  JR in EX.
- ex_jr_addr  in  32  register value for JR.
- iren  out  1  instruction-memory read enable.
- pc_select  out  2  PC next-value select: NEXT, JUMP, JUMPREGISTER or BRANCH.
- jump_data  out  32  absolute redirect target.
- pc_halt  out  1  hold the PC this cycle.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- halted  out  1  the core has stopped fetching.

## Operation
- All redirects are issued as pc_select=JUMPREGISTER with an absolute jump_data.
  - Branch target = ex_npc + {{14{ex_imm[15]}}, ex_imm, 2'b00}, computed modulo 2^32 with wrap permitted.
  - JR target = ex_jr_addr.
  - Jump target = {id_npc[31:28], id_jtarget, 2'b00}.
- Priority: an EX redirect (branch or JR) beats an ID jump, because it belongs to the older instruction.
  - If ex_branch_taken and ex_jr are both asserted, JR wins (this is a protocol error, tolerated).
  - An ID jump is ignored while stall=1 or while an EX redirect is present.
- State machine states: RUN, HOLD, DRAIN, HALTED.
- RUN:
  - iren=1.
  - On a redirect with ihit=1: apply it immediately, with pc_halt=0, pc_select=JUMPREGISTER and flushes asserted.
  - On a redirect with ihit=0: latch the target into pend_target and go to HOLD. pc_halt=1.
  - With no redirect: pc_select=NEXT, pc_halt = ~ihit | stall.
  - On halt_req with no EX redirect: go to DRAIN.
- HOLD:
  - pc_halt=1 until ihit, then apply pend_target with flushes asserted and return to RUN.
  - A new EX redirect arriving in HOLD overwrites pend_target; an ID jump does not.
- DRAIN:
  - iren stays 1 until ihit, so the outstanding fetch completes. Then go to HALTED.
  - pc_halt=1 throughout DRAIN.
  - An EX redirect arriving in DRAIN cancels the halt. It is handled exactly as in RUN (applied on ihit, or latched into HOLD).
- HALTED: iren=0, pc_halt=1, halted=1. The only exit is RST.
- Flushes:
  - An EX redirect asserts flush_ifid and flush_idex.
  - An ID jump asserts flush_ifid only.
  - Flushes are asserted in the cycle the redirect is applied (the cycle in which the PC loads the target).
- An EX redirect overrides stall. The PC loads the target even if stall=1.

## Timing
- Outputs are combinational from the state register plus the current inputs. State and pend_target are registered.
- Redirect latency: with ihit=1 the target reaches the PC at the next edge (0 added cycles). Otherwise it is applied at the edge following the first ihit.
- Reset: RST asserted forces state=RUN and pend_target=0 immediately (asynchronous). Output values during reset:
  - iren=1, pc_select=NEXT, jump_data=0.
  - pc_halt = ~ihit | stall.
  - flush_ifid=0, flush_idex=0, halted=0.
- RST asserted in the middle of HOLD or DRAIN discards pend_target and any pending halt.
- halted rises in the cycle after the draining ihit and stays high.

## Structure
- Shared package: a fetch_state_t enum (RUN, HOLD, DRAIN, HALTED) and the pc_select encodings (NEXT=0, JUMP, JUMPREGISTER, BRANCH), reusing the existing PC-select type.
- Optional sub-module redirect_arb: purely combinational priority selection and target computation, producing redirect_valid, redirect_target and redirect_is_ex.

## Test plan
- Reset, then ihit=1 continuously with no events → iren=1, pc_select=NEXT, pc_halt=0 every cycle.
- ex_branch_taken=1, ex_npc=0x100, ex_imm=0xFFFE, ihit=1 → jump_data=0xF8, pc_select=JUMPREGISTER, flush_ifid=1, flush_idex=1, pc_halt=0.
- id_jump=1 (id_npc=0x4000_0010, id_jtarget=0x40) and ex_jr=1 (ex_jr_addr=0x200) in the same cycle → jump_data=0x200, flush_idex=1.
  - Repeat with only id_jump → jump_data=0x4000_0100, flush_ifid=1, flush_idex=0.
- Branch taken while ihit=0 for 3 cycles → pc_halt=1 for 3 cycles and state=HOLD. On the ihit cycle, jump_data equals the latched target and flushes are asserted.
- halt_req with ihit=0 for 2 cycles, then ihit → DRAIN for those cycles, then halted=1 and iren=0 persistently. A subsequent RST returns to RUN.
- EX redirect while in DRAIN (ihit=1) → halt cancelled, redirect applied, state=RUN, halted stays 0.
